// File: rtl/dag_addr_sched.sv
// dag_addr_sched
//   Shares the DAG's single 15-bit carry-lookahead adder between two
//   address requesters, A and B. Each request is a circular-buffer
//   post-modify: new offset = (offset + modifier) mod length, computed in
//   one or two adder passes.
//
// Optional feature macro: DAG_BITREV_EN
//   When defined, adds brev_a/brev_b. A granted request with brev=1 is a
//   single-pass reverse-carry add (FFT addressing), len is ignored, and
//   res_wrap is 0.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   req_x              level request, held until ack_x (x = a, b)
//   off_x              current offset within the buffer (unsigned)
//   mod_x              modifier, two's complement
//   len_x              buffer length, 0 = linear (no wrap)
//   brev_x             bit-reversed addressing (DAG_BITREV_EN only)
//   ack_x              one-cycle pulse, res valid for requester x
//   res                resulting offset, holds last value outside ack
//   res_wrap           result came from the second pass (wrap occurred)
//   busy               sequencer not idle
//
// Sub-module cla15: 15-bit carry-lookahead adder, 4-bit groups.

module cla15 (
    input  logic [14:0] a,
    input  logic [14:0] b,
    input  logic        cin,
    output logic [14:0] sum
);
    logic [13:0] g;
    logic [14:0] p;
    logic [14:0] c;
    logic [2:0]  gg;
    logic [2:0]  gp;
    logic [3:0]  gc;

    // The top bit's generate would only feed the carry-out, which nobody needs.
    assign g = a[13:0] & b[13:0];
    assign p = a ^ b;

    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int k = 0; k < 3; k++) begin
            gp[k] = 1'b1;
            for (int j = 0; j < 4; j++) begin
                gg[k] = g[4*k+j] | (p[4*k+j] & gg[k]);
                gp[k] = gp[k] & p[4*k+j];
            end
        end
        gc[0] = cin;
        for (int k = 0; k < 3; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        c[0] = gc[0];
        for (int i = 1; i < 15; i++) begin
            if ((i % 4) == 0) begin
                c[i] = gc[i/4];
            end else begin
                c[i] = g[i-1] | (p[i-1] & c[i-1]);
            end
        end
    end

    assign sum = p ^ c;
endmodule

// State table
//   state | meaning
//   IDLE  | waiting for a request; grants and latches operands
//   P1    | adder pass 1: s = off + mod
//   P2    | adder pass 2: s - len (mod >= 0) or s + len (mod < 0)
//   DONE  | result registered, owner's ack high, pointer updated
module dag_addr_sched #(
    parameter int AW        = 15,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic [AW-1:0] off_a,
    input  logic [AW-1:0] mod_a,
    input  logic [AW-1:0] len_a,
    input  logic          req_b,
    input  logic [AW-1:0] off_b,
    input  logic [AW-1:0] mod_b,
    input  logic [AW-1:0] len_b,
`ifdef DAG_BITREV_EN
    input  logic          brev_a,
    input  logic          brev_b,
`endif
    output logic          ack_a,
    output logic          ack_b,
    output logic [AW-1:0] res,
    output logic          res_wrap,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, P1, P2, DONE} state_t;

    state_t        state;
    logic          owner_b;
    logic          last_b;
    logic          grant_b;
    logic [AW-1:0] off_r;
    logic [AW-1:0] mod_r;
    logic [AW-1:0] len_r;
    logic [AW-1:0] s_r;
    logic [AW-1:0] add_a;
    logic [AW-1:0] add_b;
    logic [AW-1:0] add_sum;
    logic          add_cin;
    logic          fin;
    logic          fin_wrap;
    logic [AW-1:0] fin_res;

`ifdef DAG_BITREV_EN
    logic brev_r;

    function automatic logic [13:0] rev14(input logic [13:0] v);
        logic [13:0] r;
        for (int i = 0; i < 14; i++) begin
            r[i] = v[13-i];
        end
        return r;
    endfunction
`endif

    // last_b = 1 means B was served last, so A wins the next tie.
    assign grant_b = req_b & (~req_a | (~FIXED_PRI & ~last_b));

    // Outside P1 the mux sits on the pass-2 selection, so the adder inputs
    // only move when s_r/len_r/mod_r move.
    always_comb begin
        add_a   = s_r;
        add_b   = mod_r[AW-1] ? len_r : ~len_r;
        add_cin = ~mod_r[AW-1];
        if (state == P1) begin
            add_a   = off_r;
            add_b   = mod_r;
            add_cin = 1'b0;
`ifdef DAG_BITREV_EN
            if (brev_r) begin
                add_a = {1'b0, rev14(off_r[13:0])};
                add_b = {1'b0, rev14(mod_r[13:0])};
            end
`endif
        end
    end

    cla15 u_cla (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum)
    );

    // fin: the current pass produces the final result.
    always_comb begin
        fin      = 1'b0;
        fin_res  = add_sum;
        fin_wrap = 1'b0;
        case (state)
            P1: begin
                // A negative modifier that stays non-negative needs no correction.
                if ((len_r == '0) || (mod_r[AW-1] && !add_sum[AW-1])) begin
                    fin = 1'b1;
                end
`ifdef DAG_BITREV_EN
                if (brev_r) begin
                    fin     = 1'b1;
                    fin_res = {1'b0, rev14(add_sum[13:0])};
                end
`endif
            end
            P2: begin
                fin = 1'b1;
                // Forward case: s - len negative means no wrap, keep s.
                if (!mod_r[AW-1] && add_sum[AW-1]) begin
                    fin_res = s_r;
                end else begin
                    fin_wrap = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner_b  <= 1'b0;
            last_b   <= 1'b1;
            off_r    <= '0;
            mod_r    <= '0;
            len_r    <= '0;
            s_r      <= '0;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            res      <= '0;
            res_wrap <= 1'b0;
            busy     <= 1'b0;
`ifdef DAG_BITREV_EN
            brev_r   <= 1'b0;
`endif
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        state   <= P1;
                        busy    <= 1'b1;
                        owner_b <= grant_b;
                        off_r   <= grant_b ? off_b : off_a;
                        mod_r   <= grant_b ? mod_b : mod_a;
                        len_r   <= grant_b ? len_b : len_a;
`ifdef DAG_BITREV_EN
                        brev_r  <= grant_b ? brev_b : brev_a;
`endif
                    end
                end
                P1, P2: begin
                    s_r <= add_sum;
                    if (fin) begin
                        state    <= DONE;
                        res      <= fin_res;
                        res_wrap <= fin_wrap;
                        ack_a    <= ~owner_b;
                        ack_b    <= owner_b;
                    end else begin
                        state <= P2;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    last_b <= owner_b;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dag_addr_sched.sv
// Bench for dag_addr_sched: directed pinned cases, contention, reset
// abort, then randomized legal requests against a transaction-level model.
module tb_dag_addr_sched;
    localparam bit FIXED_PRI = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   = 1'b1;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [14:0] off_a = '0;
    logic [14:0] mod_a = '0;
    logic [14:0] len_a = '0;
    logic [14:0] off_b = '0;
    logic [14:0] mod_b = '0;
    logic [14:0] len_b = '0;
    logic        brev_a = 1'b0;
    logic        brev_b = 1'b0;
    logic        ack_a, ack_b, res_wrap, busy;
    logic [14:0] res;
    logic        ack_a2, ack_b2, wrap2, busy2;
    logic [14:0] res2;

    dag_addr_sched #(.AW(15), .FIXED_PRI(FIXED_PRI)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .off_a(off_a), .mod_a(mod_a), .len_a(len_a),
        .req_b(req_b), .off_b(off_b), .mod_b(mod_b), .len_b(len_b),
`ifdef DAG_BITREV_EN
        .brev_a(brev_a), .brev_b(brev_b),
`endif
        .ack_a(ack_a), .ack_b(ack_b), .res(res), .res_wrap(res_wrap), .busy(busy)
    );

    // Fixed-priority instance with both requesters permanently asserted.
    dag_addr_sched #(.AW(15), .FIXED_PRI(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .req_a(1'b1), .off_a(15'd1), .mod_a(15'd1), .len_a(15'd0),
        .req_b(1'b1), .off_b(15'd3), .mod_b(15'd3), .len_b(15'd0),
`ifdef DAG_BITREV_EN
        .brev_a(1'b0), .brev_b(1'b0),
`endif
        .ack_a(ack_a2), .ack_b(ack_b2), .res(res2), .res_wrap(wrap2), .busy(busy2)
    );

    int n_cmp = 0;
    int n_err = 0;
    int fp_a  = 0;
    int fp_b  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] rev14(input logic [13:0] v);
        logic [13:0] r;
        for (int i = 0; i < 14; i++) r[i] = v[13-i];
        return r;
    endfunction

    // Expected result straight from the arithmetic definition.
    function automatic void predict(input logic [14:0] off, input logic [14:0] mod,
                                    input logic [14:0] len, input logic brev,
                                    output logic [14:0] r, output logic w, output int lat);
        int ms, s, l;
        logic [13:0] t;
        ms  = mod[14] ? int'(mod) - 32768 : int'(mod);
        s   = int'(off) + ms;
        l   = int'(len);
        lat = 2;
        w   = 1'b0;
        if (brev) begin
            t = rev14(off[13:0]) + rev14(mod[13:0]);
            r = {1'b0, rev14(t)};
        end else if (l == 0) begin
            r = 15'(s);
        end else begin
            r   = 15'(((s % l) + l) % l);
            w   = (s < 0) || (s >= l);
            lat = (ms >= 0 || s < 0) ? 3 : 2;
        end
    endfunction

    // Transaction-level model: a grant occupies the adder for lat cycles,
    // ack appears lat cycles after the grant cycle, then one idle cycle.
    bit          m_started = 1'b0;
    int          m_left    = 0;
    logic        m_last_b  = 1'b1;
    logic        m_owner_b = 1'b0;
    logic        m_gb;
    logic [14:0] m_res     = '0;
    logic        m_wrap    = 1'b0;
    logic        m_ack_a   = 1'b0;
    logic        m_ack_b   = 1'b0;
    logic        m_busy    = 1'b0;
    logic [14:0] p_res;
    logic        p_wrap;
    int          p_lat;

    always @(posedge clk) begin
        m_started = 1'b1;
        if (rst) begin
            m_left   = 0;
            m_last_b = 1'b1;
            m_res    = '0;
            m_wrap   = 1'b0;
            m_ack_a  = 1'b0;
            m_ack_b  = 1'b0;
            m_busy   = 1'b0;
        end else begin
            m_ack_a = 1'b0;
            m_ack_b = 1'b0;
            if (m_left == 0) begin
                if (req_a || req_b) begin
                    m_gb      = req_b && (!req_a || (!FIXED_PRI && !m_last_b));
                    m_last_b  = m_gb;
                    m_owner_b = m_gb;
                    if (m_gb) predict(off_b, mod_b, len_b, brev_b, p_res, p_wrap, p_lat);
                    else      predict(off_a, mod_a, len_a, brev_a, p_res, p_wrap, p_lat);
                    m_left = p_lat;
                    m_busy = 1'b1;
                end
            end else begin
                m_left--;
                if (m_left == 1) begin
                    m_ack_a = !m_owner_b;
                    m_ack_b = m_owner_b;
                    m_res   = p_res;
                    m_wrap  = p_wrap;
                end else if (m_left == 0) begin
                    m_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("ack_a", 32'(ack_a), 32'(m_ack_a));
            chk("ack_b", 32'(ack_b), 32'(m_ack_b));
            chk("busy",  32'(busy),  32'(m_busy));
            chk("res",   32'(res),   32'(m_res));
            if (m_ack_a || m_ack_b) chk("res_wrap", 32'(res_wrap), 32'(m_wrap));
            if (!rst) begin
                if (ack_b2) fp_b++;
                if (ack_a2) begin
                    fp_a++;
                    chk("fp_res",  32'(res2),  32'd2);
                    chk("fp_wrap", 32'(wrap2), 32'd0);
                    chk("fp_busy", 32'(busy2), 32'd1);
                end
            end
        end
    end

    task automatic run_req(input bit sel_b, input logic [14:0] off, input logic [14:0] mod,
                           input logic [14:0] len, input logic brev,
                           input logic [14:0] e_res, input logic e_wrap, input int e_lat,
                           input string tag);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        @(negedge clk);
        if (sel_b) begin
            off_b = off; mod_b = mod; len_b = len; brev_b = brev; req_b = 1'b1;
        end else begin
            off_a = off; mod_a = mod; len_a = len; brev_a = brev; req_a = 1'b1;
        end
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            got = sel_b ? ack_b : ack_a;
        end
        req_a = 1'b0;
        req_b = 1'b0;
        chk({tag, "_ack_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_latency"}, 32'(n), 32'(e_lat));
            chk({tag, "_res"}, 32'(res), 32'(e_res));
            chk({tag, "_wrap"}, 32'(res_wrap), 32'(e_wrap));
        end
    endtask

    task automatic gen(output logic [14:0] off, output logic [14:0] mod, output logic [14:0] len);
        int l, m;
        case ($urandom_range(0, 3))
            0:       l = 0;
            1:       l = int'($urandom_range(1, 20));
            default: l = int'($urandom_range(1, 16383));
        endcase
        if (l == 0) begin
            off = 15'($urandom);
            mod = 15'($urandom);
        end else begin
            off = 15'($urandom_range(0, l - 1));
            m   = int'($urandom_range(0, 2 * l - 2)) - (l - 1);
            mod = 15'(m);
        end
        len = 15'(l);
    endtask

    int   nacks;
    logic order [4];

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack_a", 32'(ack_a), 32'd0);
        chk("rst_ack_b", 32'(ack_b), 32'd0);
        chk("rst_res",   32'(res),   32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        run_req(1'b0, 15'd100, 15'd5, 15'd0,  1'b0, 15'd105, 1'b0, 2, "a_linear");
        run_req(1'b0, 15'd9,   15'd3, 15'd10, 1'b0, 15'd2,   1'b1, 3, "a_fwd_wrap");
        run_req(1'b0, 15'd5,   15'd3, 15'd10, 1'b0, 15'd8,   1'b0, 3, "a_fwd_nowrap");
        run_req(1'b1, 15'd1, 15'h7FFD, 15'd10, 1'b0, 15'd8,  1'b1, 3, "b_bwd_wrap");
        run_req(1'b1, 15'd7, 15'h7FFD, 15'd10, 1'b0, 15'd4,  1'b0, 2, "b_bwd_nowrap");

        // Contention from a fresh reset: both held high continuously.
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        off_a = 15'd10; mod_a = 15'd1; len_a = 15'd0; brev_a = 1'b0;
        off_b = 15'd20; mod_b = 15'd2; len_b = 15'd0; brev_b = 1'b0;
        req_a = 1'b1;
        req_b = 1'b1;
        nacks = 0;
        repeat (14) begin
            @(negedge clk);
            if (ack_a || ack_b) begin
                if (nacks < 4) order[nacks] = ack_b;
                nacks++;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        chk("cont_count", 32'(nacks), 32'd5);
        for (int k = 0; k < 4; k++) begin
            chk("cont_order", 32'(order[k]), FIXED_PRI ? 32'd0 : 32'(k % 2));
        end
        repeat (4) @(negedge clk);

        // Reset while in pass 2.
        @(negedge clk);
        off_a = 15'd9; mod_a = 15'd3; len_a = 15'd10; req_a = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst   = 1'b1;
        req_a = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack",  32'(ack_a), 32'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_ack", 32'(ack_a), 32'd0);
        end
        run_req(1'b0, 15'd9, 15'd3, 15'd10, 1'b0, 15'd2, 1'b1, 3, "a_after_abort");

`ifdef DAG_BITREV_EN
        run_req(1'b0, 15'd0,     15'h2000, 15'd0, 1'b1, 15'h2000, 1'b0, 2, "brev0");
        run_req(1'b0, 15'h2000,  15'h2000, 15'd0, 1'b1, 15'h1000, 1'b0, 2, "brev1");
`endif

        // Randomized legal traffic; operands may change at any time.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            if (req_a) begin
                if (ack_a && $urandom_range(0, 3) != 0) req_a = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                req_a = 1'b1;
            end
            if (req_b) begin
                if (ack_b && $urandom_range(0, 3) != 0) req_b = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                req_b = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                gen(off_a, mod_a, len_a);
`ifdef DAG_BITREV_EN
                brev_a = ($urandom_range(0, 4) == 0);
`endif
            end
            if ($urandom_range(0, 3) == 0) begin
                gen(off_b, mod_b, len_b);
`ifdef DAG_BITREV_EN
                brev_b = ($urandom_range(0, 4) == 0);
`endif
            end
        end
        rst   = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (10) @(negedge clk);

        chk("fp_b_never", 32'(fp_b), 32'd0);
        chk("fp_a_served", 32'(fp_a > 0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end
endmodule
